// File: rtl/chart_sequencer_pkg.sv
// chart_pkg: shared types and constants for the chart sequencer.
// Entry layout is {lanes, dur} with dur in the low bits.
package chart_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY
    } state_t;

    // Duration field sits at the bottom of the ROM word.
    localparam int DUR_LSB = 0;

    // Lane field starts right above the duration field.
    localparam int DUR_W_DEF = 4;
    localparam int LANE_LSB  = DUR_LSB + DUR_W_DEF;

    // A zero duration marks the end of the chart.
    localparam int END_MARKER = 0;

    // Lane field offset for a build with a non-default duration width.
    function automatic int lane_lsb(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

endpackage

// File: rtl/chart_sequencer_if.sv
// Chart ROM bus: address out from the sequencer, data back one
// cycle later from a synchronous ROM.
interface chart_sequencer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 9
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/chart_sequencer_tempo_prescaler.sv
// tempo_prescaler: divides clk down to beat ticks.
// A period of 0 behaves like 1 (a tick every enabled cycle).
module tempo_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_period,
    output logic         o_tick
);
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_max;

    // >= keeps a shortened period from having to wrap the whole counter.
    assign w_max  = (i_period == '0) ? '0 : i_period - 1'b1;
    assign o_tick = i_en && (r_cnt >= w_max);

    // Count enabled cycles, wrapping on each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/chart_sequencer.sv
// chart_sequencer: plays a {lanes, dur} chart from an external ROM
// onto the key bus, with tempo, pause, loop and end handshake.
module chart_sequencer
    import chart_pkg::*;
#(
    parameter int N_LANES = 5,
    parameter int ADDR_W  = 7,
    parameter int DUR_W   = 4,
    parameter int TEMPO_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_pause,
    input  logic               i_loop,
    input  logic [TEMPO_W-1:0] i_tempo,
    chart_sequencer_if.master  rom,
    output logic [N_LANES-1:0] o_key,
    output logic [N_LANES-1:0] o_onset,
    output logic               o_busy,
    output logic               o_done,
    output logic [ADDR_W-1:0]  o_pos
);
    localparam int L_LANE_LSB = lane_lsb(DUR_W);
    localparam logic [ADDR_W-1:0] L_ADDR_MAX = {ADDR_W{1'b1}};

    state_t             r_state, w_state_n;
    logic [ADDR_W-1:0]  r_addr, w_addr_n;
    logic [ADDR_W-1:0]  r_pos, w_pos_n;
    logic [N_LANES-1:0] r_key, w_key_n;
    logic [N_LANES-1:0] r_onset, w_onset_n;
    logic               r_done, w_done_n;
    logic [DUR_W-1:0]   r_dur, w_dur_n;

    logic [DUR_W-1:0]   w_dur;
    logic [N_LANES-1:0] w_lanes;
    logic               w_tick;
    logic               w_end;

    assign w_dur   = rom.rom_data[DUR_LSB +: DUR_W];
    assign w_lanes = rom.rom_data[L_LANE_LSB +: N_LANES];

    assign rom.rom_addr = r_addr;
    assign o_key   = r_key;
    assign o_onset = r_onset;
    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = r_done;
    assign o_pos   = r_pos;

    tempo_prescaler #(.W(TEMPO_W)) u_presc (
        .clk      (clk),
        .rst      (rst),
        .i_en     ((r_state == S_PLAY) && !i_pause),
        .i_clr    (r_state != S_PLAY),
        .i_period (i_tempo),
        .o_tick   (w_tick)
    );

    // Next-state and datapath updates; stop overrides everything.
    always_comb begin
        w_state_n = r_state;
        w_addr_n  = r_addr;
        w_pos_n   = r_pos;
        w_key_n   = r_key;
        w_onset_n = '0;
        w_done_n  = 1'b0;
        w_dur_n   = r_dur;
        w_end     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_n = S_FETCH;
                    w_addr_n  = '0;
                end
            end
            S_FETCH: begin
                w_state_n = S_LOAD;
            end
            S_LOAD: begin
                if (w_dur == DUR_W'(END_MARKER)) begin
                    w_end = 1'b1;
                end else begin
                    w_key_n   = w_lanes;
                    w_onset_n = w_lanes;
                    w_pos_n   = r_addr;
                    w_dur_n   = w_dur;
                    w_state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_tick) begin
                    w_dur_n = (r_dur != '0) ? r_dur - 1'b1 : '0;
                    if (r_dur == DUR_W'(1)) begin
                        if (r_addr == L_ADDR_MAX) begin
                            w_end = 1'b1;
                        end else begin
                            w_addr_n  = r_addr + 1'b1;
                            w_state_n = S_FETCH;
                        end
                    end
                end
            end
        endcase
        // Looping from address 0 would replay an empty chart forever.
        if (w_end) begin
            w_addr_n = '0;
            if (i_loop && (r_addr != '0)) begin
                w_state_n = S_FETCH;
            end else begin
                w_state_n = S_IDLE;
                w_key_n   = '0;
                w_done_n  = 1'b1;
            end
        end
        if (i_stop) begin
            w_state_n = S_IDLE;
            w_addr_n  = '0;
            w_key_n   = '0;
            w_onset_n = '0;
            w_done_n  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_pos   <= '0;
            r_key   <= '0;
            r_onset <= '0;
            r_done  <= 1'b0;
            r_dur   <= '0;
        end else begin
            r_state <= w_state_n;
            r_addr  <= w_addr_n;
            r_pos   <= w_pos_n;
            r_key   <= w_key_n;
            r_onset <= w_onset_n;
            r_done  <= w_done_n;
            r_dur   <= w_dur_n;
        end
    end
endmodule

// File: doc/chart_sequencer.md
# chart_sequencer

- Parametrised note-chart player for the rhythm-game datapath.
- Walks a chart stored in an external synchronous ROM. Each entry is a lane mask plus a duration in beat ticks.
- Drives the per-lane key bus to the judge/display logic.
- Adds over the fixed-pattern player:
  - run-time tempo;
  - start/stop/pause;
  - loop mode;
  - per-lane onset pulses;
  - an end-of-chart handshake.

## Interface
Parameters:
- N_LANES, 5, number of key lanes
- ADDR_W, 7, chart ROM address width (max 128 entries)
- DUR_W, 4, entry duration field width in ticks
- TEMPO_W, 16, tempo period width in clk cycles per tick

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to play from address 0
- stop  in  1  single-cycle abort
- pause  in  1  level; freezes playback while high
- loop  in  1  level; sampled at end of chart; restart from 0 if high
- tempo  in  TEMPO_W  clk cycles per tick; 0 treated as 1
- rom_addr  out  ADDR_W  chart ROM address
- rom_data  in  N_LANES+DUR_W  ROM word {lanes, dur}; valid one cycle after rom_addr
- key  out  N_LANES  current lane mask
- onset  out  N_LANES  one-cycle pulse of the lanes set at the start of each entry
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on natural chart end without loop
- pos  out  ADDR_W  address of the entry currently playing

## Operation
Entry format:
- dur = rom_data[DUR_W-1:0]; lanes = rom_data[N_LANES+DUR_W-1:DUR_W].
- dur==0 is the end-of-chart marker.
- lanes==0 with dur>0 is a rest.

States: IDLE, FETCH, LOAD, PLAY.

IDLE:
- key=0, busy=0, rom_addr=0.
- start -> FETCH with addr=0.

FETCH:
- rom_addr=addr; one cycle; -> LOAD.
- key holds its previous value.

LOAD (rom_data valid):
- If dur==0:
  - addr!=0 and loop=1: addr<=0 -> FETCH.
  - Otherwise -> IDLE, key<=0, done pulse.
  - A marker at address 0 always terminates, which prevents an infinite empty loop.
- Else:
  - key<=lanes, onset<=lanes, pos<=addr;
  - dur_cnt<=dur, prescaler cleared;
  - -> PLAY.

PLAY:
- Prescaler counts while pause=0. tick when count==max(tempo,1)-1, then the count wraps to 0.
- On tick: dur_cnt decrements.
- On the tick where dur_cnt==1:
  - addr==2^ADDR_W-1: treated exactly as an end marker (loop/done rules above).
  - Otherwise addr<=addr+1 -> FETCH.

Control precedence:
- stop (any state): -> IDLE next cycle; key, onset and addr cleared; no done.
- stop and start in the same cycle: stop wins.
- start while busy: ignored.
- pause: freezes the prescaler and dur_cnt in PLAY only. FETCH/LOAD complete normally; key is held.

Widths:
- tempo changes take effect on the next prescaler comparison.
- dur_cnt is DUR_W bits wide and never underflows.

## Timing
- Reset values: key=0, onset=0, busy=0, done=0, pos=0, rom_addr=0; state IDLE.
- start sampled in cycle 0:
  - FETCH in cycle 1;
  - LOAD in cycle 2;
  - key/onset visible in cycle 3.
- Unpaused entry length as seen on key: dur*P + 2 cycles, where P=max(tempo,1). The +2 is the FETCH/LOAD gap, during which key holds.
- onset is high for exactly the first cycle of each entry. Repeated lanes in consecutive entries pulse again.
- done asserts the cycle after LOAD sees the marker, coincident with key returning to 0 and busy falling.
- Reset mid-playback clears everything asynchronously. No done is issued.

## Structure
- chart_pkg:
  - state enum;
  - entry field-slice localparams (DUR_LSB, LANE_LSB);
  - END_MARKER constant.
- One sub-module, tempo_prescaler (enable, clear, period -> tick), reused by the metronome block.

## Test plan
- N_LANES=5, tempo=4, ROM {0x10|2, 0x08|1, end}, start -> key=0x10 for 10 cycles then 0x08 for 6; onset pulses at cycles 3 and 13; done one cycle after the end marker is read.
- Same chart, loop=1 -> after the marker, pos returns to 0 and key=0x10 reappears 2 cycles later; done never asserts.
- pause held 7 cycles mid-entry -> entry stretched by exactly 7 cycles; key unchanged.
- stop during PLAY of entry 1 -> key=0 and busy=0 next cycle; done=0; a subsequent start replays from address 0.
- tempo=0, dur=3 -> entry lasts 3+2 cycles; ROM full of non-zero entries -> terminates after address 127 with done.
- Marker at address 0 with loop=1 -> done after one FETCH/LOAD; returns to IDLE; no onset.
